// File: rtl/otter_axi_arbiter.sv
// Two-controller to one-device AXI4-Lite arbiter (AR/R, AW/W) for the OTTER multi-hub.
// Ports: clk/rst, m0_*/m1_* controller channels, s_* device channels, owner, busy.
module otter_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t state;
  logic   last;
  logic   ar_done;
  logic   aw_done;
  logic   w_done;

  logic o_arvalid;
  logic o_rready;
  logic o_awvalid;
  logic o_wvalid;

  assign o_arvalid = owner ? m1_arvalid : m0_arvalid;
  assign o_rready  = owner ? m1_rready  : m0_rready;
  assign o_awvalid = owner ? m1_awvalid : m0_awvalid;
  assign o_wvalid  = owner ? m1_wvalid  : m0_wvalid;

  // Payloads pass straight through; only valid/ready are gated.
  assign s_araddr = owner ? m1_araddr : m0_araddr;
  assign s_awaddr = owner ? m1_awaddr : m0_awaddr;
  assign s_wdata  = owner ? m1_wdata  : m0_wdata;
  assign s_wstrb  = owner ? m1_wstrb  : m0_wstrb;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  logic in_rd;
  logic in_wr;

  assign in_rd = (state == RD);
  assign in_wr = (state == WR);

  assign s_arvalid = in_rd & o_arvalid & ~ar_done;
  assign s_rready  = in_rd & o_rready;
  assign s_awvalid = in_wr & o_awvalid & ~aw_done;
  assign s_wvalid  = in_wr & o_wvalid & ~w_done;

  logic arrdy;
  logic rvld;
  logic awrdy;
  logic wrdy;

  assign arrdy = in_rd & s_arready & ~ar_done;
  assign rvld  = in_rd & s_rvalid;
  assign awrdy = in_wr & s_awready & ~aw_done;
  assign wrdy  = in_wr & s_wready & ~w_done;

  assign m0_arready = arrdy & ~owner;
  assign m1_arready = arrdy & owner;
  assign m0_rvalid  = rvld & ~owner;
  assign m1_rvalid  = rvld & owner;
  assign m0_awready = awrdy & ~owner;
  assign m1_awready = awrdy & owner;
  assign m0_wready  = wrdy & ~owner;
  assign m1_wready  = wrdy & owner;

  logic ar_hs;
  logic r_hs;
  logic aw_hs;
  logic w_hs;
  logic rd_fin;
  logic wr_fin;

  assign ar_hs  = s_arvalid & s_arready;
  assign r_hs   = s_rvalid & s_rready;
  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign rd_fin = r_hs & (ar_done | ar_hs);
  assign wr_fin = in_wr & (aw_done | aw_hs) & (w_done | w_hs);

  logic req0;
  logic req1;
  logic gnt;
  logic g_rd;

  assign req0 = m0_arvalid | m0_awvalid;
  assign req1 = m1_arvalid | m1_awvalid;
  // A tie goes to whoever did not finish last.
  assign gnt  = (req0 & req1) ? ~last : req1;
  assign g_rd = gnt ? m1_arvalid : m0_arvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner <= gnt;
            state <= g_rd ? RD : WR;
          end
        end
        RD: begin
          if (ar_hs) ar_done <= 1'b1;
          if (rd_fin) begin
            state   <= IDLE;
            last    <= owner;
            ar_done <= 1'b0;
          end
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs) w_done <= 1'b1;
          if (wr_fin) begin
            state   <= IDLE;
            last    <= owner;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_otter_axi_arbiter.sv
// Self-checking bench for otter_axi_arbiter: directed scenarios, then
// randomized controllers/device against a transaction-level grant model.
module tb_otter_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [3:0]  s_wstrb;
  logic        owner, busy;

  always #5 clk = ~clk;

  otter_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid),
    .m0_wready(m0_wready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .owner(owner), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
    m0_awaddr = '0; m0_awvalid = 0; m0_wdata = '0;
    m0_wstrb = '0; m0_wvalid = 0;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
    m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0;
    m1_wstrb = '0; m1_wvalid = 0;
    s_arready = 0; s_rdata = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // ---- random-phase state: controllers, device, grant model ----
  bit          act[2], rd[2], ar_p[2], aw_p[2], w_p[2], r_p[2];
  logic [31:0] adr[2], dat[2];
  logic [3:0]  stb[2];
  int          gap[2];
  bit          r_owed;
  bit          mb, mo, ml;
  bit          prev_busy;
  int          g[2];

  function automatic logic [3:0] side(input bit n);
    return n ? {m1_arready, m1_rvalid, m1_awready, m1_wready}
             : {m0_arready, m0_rvalid, m0_awready, m0_wready};
  endfunction

  task automatic rand_init();
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; gap[n] = 0; g[n] = 0;
      ar_p[n] = 0; aw_p[n] = 0; w_p[n] = 0; r_p[n] = 0;
    end
    r_owed = 0; mb = 0; mo = 0; ml = 1; prev_busy = 0;
  endtask

  task automatic rand_cycle(input int gapmax);
    bit [1:0] req;
    bit hs_ar[2], hs_aw[2], hs_w[2], hs_r[2], done[2];
    for (int n = 0; n < 2; n++) begin
      if (!act[n]) begin
        if (gap[n] == 0) begin
          act[n] = 1;
          rd[n] = ($urandom_range(0, 1) == 1);
          adr[n] = $urandom; dat[n] = $urandom;
          stb[n] = 4'($urandom_range(0, 15));
          ar_p[n] = rd[n]; r_p[n] = rd[n];
          aw_p[n] = !rd[n]; w_p[n] = !rd[n];
        end else gap[n]--;
      end
    end
    m0_arvalid = act[0] & ar_p[0]; m1_arvalid = act[1] & ar_p[1];
    m0_awvalid = act[0] & aw_p[0]; m1_awvalid = act[1] & aw_p[1];
    m0_wvalid = act[0] & w_p[0];   m1_wvalid = act[1] & w_p[1];
    m0_araddr = adr[0]; m0_awaddr = adr[0];
    m1_araddr = adr[1]; m1_awaddr = adr[1];
    m0_wdata = dat[0]; m0_wstrb = stb[0];
    m1_wdata = dat[1]; m1_wstrb = stb[1];
    m0_rready = ($urandom_range(0, 1) == 1);
    m1_rready = ($urandom_range(0, 1) == 1);
    s_arready = ($urandom_range(0, 1) == 1);
    s_awready = ($urandom_range(0, 1) == 1);
    s_wready = ($urandom_range(0, 1) == 1);
    s_rvalid = r_owed & ($urandom_range(0, 1) == 1);
    s_rdata = $urandom;
    settle();
    req = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};
    if (busy && !prev_busy) g[owner]++;
    prev_busy = busy;
    if (mb) begin
      chk("r_owner", owner, mo);
      chk("r_busy", busy, 1);
      chk("r_nonowner", side(!mo), 0);
    end else begin
      chk("r_idle_busy", busy, 0);
      chk("r_idle_q", {s_arvalid, s_awvalid, s_wvalid, s_rready,
                       side(0), side(1)}, 0);
    end
    chk("r_s_arvalid", s_arvalid, mb && rd[mo] && ar_p[mo]);
    chk("r_s_awvalid", s_awvalid, mb && !rd[mo] && aw_p[mo]);
    chk("r_s_wvalid", s_wvalid, mb && !rd[mo] && w_p[mo]);
    if (s_arvalid && s_arready) chk("r_araddr", s_araddr, adr[mo]);
    if (s_awvalid && s_awready) chk("r_awaddr", s_awaddr, adr[mo]);
    if (s_wvalid && s_wready) chk("r_wdata", {s_wstrb, s_wdata},
                                  {stb[mo], dat[mo]});
    hs_ar[0] = m0_arvalid & m0_arready; hs_ar[1] = m1_arvalid & m1_arready;
    hs_aw[0] = m0_awvalid & m0_awready; hs_aw[1] = m1_awvalid & m1_awready;
    hs_w[0] = m0_wvalid & m0_wready;    hs_w[1] = m1_wvalid & m1_wready;
    hs_r[0] = m0_rvalid & m0_rready;    hs_r[1] = m1_rvalid & m1_rready;
    if (hs_r[0]) chk("r_rdata0", m0_rdata, s_rdata);
    if (hs_r[1]) chk("r_rdata1", m1_rdata, s_rdata);
    for (int n = 0; n < 2; n++) begin
      if (hs_ar[n]) ar_p[n] = 0;
      if (hs_aw[n]) aw_p[n] = 0;
      if (hs_w[n]) w_p[n] = 0;
      if (hs_r[n]) r_p[n] = 0;
      done[n] = act[n] & !ar_p[n] & !aw_p[n] & !w_p[n] & !r_p[n];
    end
    if (s_rvalid && s_rready) r_owed = 0;
    if (s_arvalid && s_arready) r_owed = 1;
    if (!mb) begin
      if (req != 0) begin
        mb = 1;
        mo = (req == 2'b11) ? !ml : req[1];
      end
    end else if (done[mo]) begin
      mb = 0;
      ml = mo;
    end
    for (int n = 0; n < 2; n++) begin
      if (done[n]) begin
        act[n] = 0;
        gap[n] = $urandom_range(0, gapmax);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1;
    clr();
    tick();
    tick();
    rst = 0;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_outs", {s_arvalid, s_awvalid, s_wvalid, s_rready,
                     side(0), side(1)}, 0);

    // m0 read alone with a slow device
    m0_arvalid = 1; m0_araddr = 32'h100; m0_rready = 1;
    settle();
    chk("t1_c1_busy", busy, 0);
    chk("t1_c1_arvalid", s_arvalid, 0);
    tick();
    s_arready = 1;
    settle();
    chk("t1_c2_arvalid", s_arvalid, 1);
    chk("t1_c2_araddr", s_araddr, 32'h100);
    chk("t1_c2_arready", m0_arready, 1);
    chk("t1_c2_owner", {busy, owner}, 2'b10);
    tick();
    m0_arvalid = 0; s_arready = 0;
    settle();
    chk("t1_c3_arvalid", s_arvalid, 0);
    tick();
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    settle();
    chk("t1_c4_rvalid", m0_rvalid, 1);
    chk("t1_c4_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_c4_rready", s_rready, 1);
    chk("t1_c4_m1", side(1), 0);
    tick();
    s_rvalid = 0;
    settle();
    chk("t1_c5_busy", busy, 0);

    // m0 read and m1 write together; device always ready
    clr();
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h300; m0_rready = 1;
    m1_awvalid = 1; m1_awaddr = 32'h200; m1_wvalid = 1;
    m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
    s_arready = 1; s_rvalid = 1; s_rdata = 32'hCAFE0001;
    s_awready = 1; s_wready = 1;
    settle();
    chk("t2_idle_q", {busy, s_arvalid, s_awvalid, s_wvalid,
                      side(0), side(1)}, 0);
    tick();
    chk("t2_own0", {busy, owner}, 2'b10);
    chk("t2_araddr", s_araddr, 32'h300);
    chk("t2_same_cyc", {s_arvalid, m0_arready, m0_rvalid}, 3'b111);
    chk("t2_rdata", m0_rdata, 32'hCAFE0001);
    chk("t2_m1_masked", {s_awvalid, s_wvalid, side(1)}, 0);
    tick();
    m0_arvalid = 0;
    settle();
    chk("t2_gap_idle", {busy, s_awvalid}, 0);
    tick();
    chk("t2_own1", {busy, owner}, 2'b11);
    chk("t2_aw", {s_awvalid, s_awaddr}, {1'b1, 32'h200});
    chk("t2_w", {s_wvalid, s_wstrb, s_wdata}, {1'b1, 4'b0011, 32'h12345678});
    chk("t2_m1_rdy", {m1_awready, m1_wready}, 2'b11);
    chk("t2_m0_masked", side(0), 0);
    tick();
    m1_awvalid = 0; m1_wvalid = 0;
    settle();
    chk("t2_done", busy, 0);

    // W accepted well ahead of AW; W must not be re-presented
    clr();
    m0_awvalid = 1; m0_awaddr = 32'h400; m0_wvalid = 1;
    m0_wdata = 32'hA5A5A5A5; m0_wstrb = 4'hF;
    tick();
    s_wready = 1;
    settle();
    chk("t4_w1", {s_awvalid, s_wvalid, m0_wready, m0_awready}, 4'b1110);
    tick();
    settle();
    chk("t4_w_gated", {s_wvalid, m0_wready}, 2'b00);
    tick();
    s_awready = 1;
    settle();
    chk("t4_aw", {s_awvalid, m0_awready, s_wvalid, busy}, 4'b1101);
    tick();
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    settle();
    chk("t4_done", busy, 0);

    // reset while m1 read has R pending
    clr();
    m1_arvalid = 1; m1_araddr = 32'h500;
    tick();
    s_arready = 1;
    settle();
    chk("t6_ar", {owner, m1_arready}, 2'b11);
    tick();
    m1_arvalid = 0; s_arready = 0; s_rvalid = 1;
    settle();
    chk("t6_rpend", {m1_rvalid, s_rready}, 2'b10);
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("t6_after_rst", {busy, owner, s_arvalid, s_rready, m1_rvalid}, 0);
    s_rvalid = 0;
    m0_arvalid = 1; m0_araddr = 32'h600; m1_arvalid = 1; m1_araddr = 32'h700;
    tick();
    chk("t6_tie_m0", {busy, owner, s_araddr}, {2'b10, 32'h600});
    s_arready = 1; s_rvalid = 1; m0_rready = 1;
    settle();
    chk("t6_m1_masked", side(1), 0);
    tick();
    m0_arvalid = 0;
    settle();
    chk("t6_idle", busy, 0);
    tick();
    m1_rready = 1;
    settle();
    chk("t6_m1_next", {busy, owner, m1_rvalid}, 3'b111);
    tick();
    clr();
    settle();
    chk("t6_done", busy, 0);

    // both controllers always requesting: grants must alternate
    do_reset();
    rand_init();
    for (int i = 0; i < 400; i++) rand_cycle(0);
    chk("alt_balance", (g[0] == g[1]) || (g[0] == g[1] + 1), 1);
    chk("alt_progress", g[0] >= 6, 1);

    // sparse random traffic
    clr();
    do_reset();
    rand_init();
    for (int i = 0; i < 3000; i++) rand_cycle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/otter_axi_arbiter.md
Name: otter_axi_arbiter

Overview:
- Two-controller to one-device AXI4-Lite arbiter (read and write address/data channels, no B channel) for the OTTER multi-hub.
- Sits between two otter-to-AXI translators (m0 = instruction fetch, m1 = data load/store) and the single shared memory port (s).
- Grants the bus to one controller per transaction, round-robin, and holds the grant until the transaction completes.
- Steers handshakes and masks ready/valid to the controller that does not hold the grant.

Parameters:
- ADDR_W, 32, address width of all ar/aw channels.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  system clock; all state on posedge clk.
- rst  in  1  synchronous, active-high reset.
- mN_araddr (N=0,1)  in  ADDR_W  controller N read address.
- mN_arvalid  in  1  / mN_arready  out  1  controller N AR handshake.
- mN_rdata  out  DATA_W  read data; s_rdata broadcast to both controllers.
- mN_rvalid  out  1  / mN_rready  in  1  controller N R handshake.
- mN_awaddr  in  ADDR_W  controller N write address.
- mN_awvalid  in  1  / mN_awready  out  1  controller N AW handshake.
- mN_wdata  in  DATA_W  / mN_wstrb  in  DATA_W/8  controller N write data and strobes.
- mN_wvalid  in  1  / mN_wready  out  1  controller N W handshake.
- s_araddr, s_arvalid out; s_arready in  device AR channel.
- s_rdata in; s_rvalid in; s_rready out  device R channel.
- s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid out; s_awready, s_wready in  device AW/W channels.
- owner  out  1  index of the current or most recent grant holder.
- busy  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, RD (AR/R in flight), WR (AW/W in flight). Registers: state, owner, last (last completed owner), ar_done, aw_done, w_done.
- Reset: state=IDLE, owner=0, last=1 (so m0 wins the first tie), all done flags 0. Every s_* valid/ready output and every mN ready/valid output is 0 in IDLE and on the cycle after rst.
- Reset mid-transaction abandons the transaction with no completion signalled. Outputs fall in the cycle after rst is sampled high.
- Request of N: mN_arvalid | mN_awvalid.
- IDLE arbitration:
  - Only one controller requesting: grant it.
  - Both requesting: grant !last.
  - Granted controller with arvalid goes to RD; otherwise it goes to WR. Read has priority when one controller raises both.
  - Grant is registered, so there is exactly 1 cycle of arbitration latency. No s_* valid is driven in IDLE.
- RD:
  - s_araddr=m[owner]_araddr; s_arvalid=m[owner]_arvalid & !ar_done.
  - m[owner]_arready=s_arready & !ar_done.
  - s_rready=m[owner]_rready; m[owner]_rvalid=s_rvalid.
  - ar_done is set on the AR handshake.
  - Complete on the R handshake (s_rvalid & s_rready) when ar_done is set or the AR handshake happens in the same cycle.
  - On completion: state=IDLE, last=owner, flags cleared.
- WR:
  - Forward awaddr/awvalid and wdata/wstrb/wvalid of owner, each gated off once its done flag is set.
  - m[owner]_awready/wready follow s_ with the same gating.
  - AW and W handshakes are tracked independently (either order, or same cycle).
  - Complete when both are done (including same-cycle completion of the last one), then go to IDLE with last=owner.
- Non-owner: all of its ready/valid outputs are held 0. Its requests stay pending; it is never dropped.
- No combinational path from any mN valid to any s valid while in IDLE.
- Starvation bound: a requester waits at most one full transaction of the other controller plus 1 cycle.
- Back-to-back: the owner can re-request in the IDLE cycle after completion. If the other controller is also requesting, the other controller wins.
- Address and data pass through unmodified; no alignment or slicing is done here.

Test Plan:
- Reset then m0 read 0x100 alone; device gives arready at cycle 2 and rvalid rdata=0xDEADBEEF at cycle 4 -> m0_rvalid at cycle 4 with 0xDEADBEEF; m1 ready signals stay 0; busy drops at cycle 5.
- m0 read and m1 write (awaddr 0x200, wdata 0x12345678, wstrb 4'b0011) raised in the same cycle after reset -> m0 granted first; m1 granted in the IDLE cycle after m0 completes; s_wstrb=4'b0011.
- Both controllers requesting continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 on owner.
- Write where device gives wready 2 cycles before awready -> W is not re-presented (s_wvalid=0 after its handshake); completes on awready.
- AR and R handshakes in the same cycle (device arready=rvalid=1, controller rready=1) -> completes in one RD cycle; state returns to IDLE.
- rst asserted mid-RD with s_rvalid pending -> next cycle state=IDLE and s_arvalid=s_rready=0; next request arbitrates as after reset (m0 wins a tie).
